sa_ctrl: RTL
============

// Module: sa_ctrl
// PURPOSE
// Job sequencer in front of sa_top. Accepts one job as 2*SIZE input rows: SIZE rows of B, then SIZE rows of A.
// Drives sa_top's write, A-stream and C-drain ports in order.
// Captures the SIZE result rows into a local buffer and replays them on a ready/valid output stream.
// One job in flight; a new job starts only after the last C row of the previous job is accepted.
// PARAMETERS
// WIDTH     16       element width (matches sa_top)
// SIZE      4        array dimension; rows per matrix (>=2)
// DRAIN_LAT 2*SIZE-1 idle cycles from last A row issued to first o_sa_c_vld
// TIMEOUT   4*SIZE   max cycles in DRAIN waiting for SIZE captured rows
// PORTS
// clk        in  1          clock
// rst        in  1          synchronous, active-high reset
// i_start    in  1          start job (pulse); ignored unless state==IDLE
// o_busy     out 1          high in every state except IDLE
// i_row_vld  in  1          input row valid
// o_row_rdy  out 1          input row ready (LOAD_B/LOAD_A only)
// i_row      in  SIZE*WIDTH input row, [SIZE-1:0][WIDTH-1:0]
// o_sa_we    out 1          -> sa_top.i_we
// o_sa_a_vld out 1          -> sa_top.i_a_vld
// o_sa_rows  out SIZE*WIDTH -> sa_top.i_a_rows
// o_sa_c_vld out 1          -> sa_top.i_c_vld
// i_sa_c_vld in  1          <- sa_top.o_c_vld
// i_sa_c_rows in SIZE*WIDTH <- sa_top.o_c_rows
// o_res_vld  out 1          result row valid
// i_res_rdy  in  1          result row ready
// o_res_row  out SIZE*WIDTH result row
// o_res_last out 1          with o_res_vld on the SIZE-th row of the job
// o_err      out 1          sticky; set by timeout or overflow; cleared by an accepted i_start or rst
// BEHAVIOUR
// - Reset: state=IDLE, all counters=0, buffer empty.
//   o_busy, o_row_rdy, o_sa_we, o_sa_a_vld, o_sa_c_vld, o_res_vld, o_res_last, o_err all 0; o_sa_rows=0.
// - FSM: IDLE -> LOAD_B -> LOAD_A -> WAIT -> DRAIN -> OUT -> IDLE.
//   - IDLE -> LOAD_B: on i_start; o_err cleared the same cycle.
//   - LOAD_B / LOAD_A: beat = i_row_vld & o_row_rdy; beat_cnt counts 0..SIZE-1.
//     On beat with beat_cnt==SIZE-1: wrap to 0 and advance state.
//   - WAIT: wait_cnt counts DRAIN_LAT cycles, then enter DRAIN.
//   - DRAIN: o_sa_c_vld=1 for exactly SIZE consecutive cycles from DRAIN entry.
//     Leave for OUT when cap_cnt==SIZE, or when tmo_cnt reaches TIMEOUT (set o_err, go to OUT with the rows captured so far).
//   - OUT: present the buffer; go to IDLE when the buffer empties. If cap_cnt==0, go to IDLE directly.
// - Issue path is registered, 1-cycle latency:
//   - a beat at cycle t in LOAD_B gives o_sa_we=1, o_sa_rows=i_row at t+1;
//   - a beat in LOAD_A gives o_sa_a_vld=1 at t+1.
//   - Without a beat, we/a_vld=0 at t+1 and o_sa_rows holds its last value.
//   - we and a_vld are never high together.
// - Stall: deasserting i_row_vld mid-load pauses the job indefinitely; no rows are skipped or duplicated.
//   sa_top's internal write pointer stays aligned because exactly SIZE we-pulses are issued per job.
// - Capture: in WAIT or DRAIN, each cycle with i_sa_c_vld=1 pushes i_sa_c_rows into the buffer.
//   - cap_cnt counts 0..SIZE.
//   - A capture with cap_cnt==SIZE is dropped and sets o_err (overflow).
//   - i_sa_c_vld in any other state is ignored.
// - Output: FIFO order, standard ready/valid.
//   - o_res_row is stable while o_res_vld & !i_res_rdy.
//   - o_res_last is high on the final buffered row (on a timeout, the last captured row).
// - Simultaneous events: i_start in a non-IDLE state is ignored. A capture and a pop never coincide (pops only in OUT).
// - Reset mid-operation: controller returns to reset state next cycle and buffer contents are discarded.
//   sa_top has no reset, so the integrator must not assert rst during LOAD_B except at power-on.
//   Its we-pointer would otherwise be misaligned; this is a stated system limitation.
// STRUCTURE
// - sa_pkg: typedef enum logic [2:0] {IDLE, LOAD_B, LOAD_A, WAIT, DRAIN, OUT} sa_state_t;
//   also row_t parameterised type helpers and the default DRAIN_LAT/TIMEOUT constants.
// - Sub-module sa_res_buf: SIZE-deep, WIDTH*SIZE-wide synchronous FIFO.
//   Ports: push, pop, full, empty, count. Synchronous reset to empty.
// - Top level holds the FSM, beat/wait/cap/tmo counters, the issue register and the error flag.
// TESTING (SIZE=4, WIDTH=16)
// - Identity: B=I, A rows {1,2,3,4},{5,6,7,8},... with the sa_top model, i_res_rdy=1
//   -> 4 result rows equal to A; o_res_last on row 4; o_err=0; o_busy falls after the last pop.
// - Input stall: i_row_vld low 3 cycles after row 2 and after row 6
//   -> exactly 4 o_sa_we then 4 o_sa_a_vld pulses, each 1 cycle after its beat; result unchanged.
// - Output backpressure: i_res_rdy low 5 cycles on row 2 -> o_res_row held stable; no row lost; i_start meanwhile ignored.
// - Timeout: stub sa_top returns only 2 o_c_vld -> o_err=1 at tmo_cnt=16;
//   2 rows replayed, o_res_last on row 2; next i_start clears o_err.
// - Overflow: stub returns 5 o_c_vld in DRAIN -> 4 rows buffered, o_err=1.
// - Reset mid LOAD_A (after 2 A beats) -> next cycle o_busy=0, o_row_rdy=0, o_sa_* =0, o_res_vld=0.

Source files
------------

// File: rtl/sa_pkg.sv
// sa_pkg: shared types and default constants for the sa_ctrl job sequencer.
//   sa_state_t      controller state encoding
//   SA_*_DEF        default geometry / timing constants
//   sa_drain_lat()  drain latency derived from array size
//   sa_timeout()    drain timeout derived from array size
//   sa_row_bits()   flat bit width of one row
package sa_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_B = 3'd1,
        LOAD_A = 3'd2,
        WAIT   = 3'd3,
        DRAIN  = 3'd4,
        OUT    = 3'd5
    } sa_state_t;

    localparam int SA_WIDTH_DEF     = 16;
    localparam int SA_SIZE_DEF      = 4;
    localparam int SA_DRAIN_LAT_DEF = 2 * SA_SIZE_DEF - 1;
    localparam int SA_TIMEOUT_DEF   = 4 * SA_SIZE_DEF;

    function automatic int sa_drain_lat(input int size);
        return 2 * size - 1;
    endfunction

    function automatic int sa_timeout(input int size);
        return 4 * size;
    endfunction

    function automatic int sa_row_bits(input int size, input int width);
        return size * width;
    endfunction

endpackage

// File: rtl/sa_res_buf.sv
// sa_res_buf: SIZE-deep synchronous FIFO holding one job's result rows.
//   clk, rst         clock, synchronous active-high reset (to empty)
//   i_push, i_data   write strobe and row; ignored when full
//   i_pop            read strobe; ignored when empty
//   o_data           head row, stable until popped
//   o_full, o_empty  occupancy flags
//   o_count          rows currently stored (0..SIZE)
module sa_res_buf
    import sa_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEF,
    parameter int SIZE  = SA_SIZE_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_push,
    input  logic [SIZE-1:0][WIDTH-1:0]    i_data,
    input  logic                          i_pop,
    output logic [SIZE-1:0][WIDTH-1:0]    o_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(SIZE+1)-1:0]     o_count
);

    localparam int PTR_W = $clog2(SIZE);
    localparam int CNT_W = $clog2(SIZE + 1);

    logic [SIZE-1:0][WIDTH-1:0] r_mem [SIZE];
    logic [PTR_W-1:0]           r_wr_ptr;
    logic [PTR_W-1:0]           r_rd_ptr;
    logic [CNT_W-1:0]           r_count;
    logic                       w_do_push;
    logic                       w_do_pop;

    assign o_full    = (r_count == CNT_W'(SIZE));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SIZE - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage needs no reset: emptiness is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sa_ctrl.sv
// sa_ctrl: job sequencer in front of the sa_top systolic array.
// Loads SIZE rows of B then SIZE rows of A, waits out the array latency,
// drains SIZE result rows into a local buffer and replays them on a
// ready/valid stream.
//   clk, rst                      clock, synchronous active-high reset
//   i_start / o_busy              job start pulse / not-idle indicator
//   i_row_vld, o_row_rdy, i_row   input row stream (B rows, then A rows)
//   o_sa_we, o_sa_a_vld, o_sa_rows  registered issue to sa_top
//   o_sa_c_vld                    drain request to sa_top
//   i_sa_c_vld, i_sa_c_rows       result rows from sa_top
//   o_res_vld, i_res_rdy, o_res_row, o_res_last  result stream
//   o_err                         sticky timeout / overflow flag
//
// state  | meaning
// IDLE   | no job; waiting for i_start
// LOAD_B | accepting SIZE B rows, issued as sa_top writes
// LOAD_A | accepting SIZE A rows, issued as sa_top A-stream
// WAIT   | last A row issued; letting the array pipeline settle
// DRAIN  | requesting results, capturing rows into the buffer
// OUT    | replaying captured rows; back to IDLE once empty
module sa_ctrl
    import sa_pkg::*;
#(
    parameter int WIDTH     = SA_WIDTH_DEF,
    parameter int SIZE      = SA_SIZE_DEF,
    parameter int DRAIN_LAT = sa_drain_lat(SIZE),
    parameter int TIMEOUT   = sa_timeout(SIZE)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_start,
    output logic                       o_busy,
    input  logic                       i_row_vld,
    output logic                       o_row_rdy,
    input  logic [SIZE-1:0][WIDTH-1:0] i_row,
    output logic                       o_sa_we,
    output logic                       o_sa_a_vld,
    output logic [SIZE-1:0][WIDTH-1:0] o_sa_rows,
    output logic                       o_sa_c_vld,
    input  logic                       i_sa_c_vld,
    input  logic [SIZE-1:0][WIDTH-1:0] i_sa_c_rows,
    output logic                       o_res_vld,
    input  logic                       i_res_rdy,
    output logic [SIZE-1:0][WIDTH-1:0] o_res_row,
    output logic                       o_res_last,
    output logic                       o_err
);

    localparam int BEAT_W = $clog2(SIZE);
    localparam int WAIT_W = $clog2(DRAIN_LAT + 1);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);
    localparam int CAP_W  = $clog2(SIZE + 1);

    sa_state_t                  r_state;
    sa_state_t                  w_next;
    logic [BEAT_W-1:0]          r_beat_cnt;
    logic [WAIT_W-1:0]          r_wait_cnt;
    logic [TMO_W-1:0]           r_tmo_cnt;
    logic [CAP_W-1:0]           r_cap_cnt;
    logic                       r_err;
    logic                       r_we;
    logic                       r_a_vld;
    logic [SIZE-1:0][WIDTH-1:0] r_rows;

    logic                       w_beat;
    logic                       w_last_beat;
    logic                       w_cap_any;
    logic                       w_push;
    logic                       w_ovf;
    logic                       w_pop;
    logic                       w_tmo_hit;
    logic                       w_buf_full;
    logic                       w_buf_empty;
    logic [CAP_W-1:0]           w_buf_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        o_busy      = 1'b1;
        o_row_rdy   = 1'b0;
        o_sa_c_vld  = 1'b0;
        o_res_vld   = 1'b0;
        w_beat      = 1'b0;
        w_last_beat = 1'b0;
        w_cap_any   = 1'b0;
        w_tmo_hit   = 1'b0;
        case (r_state)
            IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_next = LOAD_B;
                end
            end
            LOAD_B: begin
                o_row_rdy   = 1'b1;
                w_beat      = i_row_vld;
                w_last_beat = i_row_vld && (r_beat_cnt == BEAT_W'(SIZE - 1));
                if (w_last_beat) begin
                    w_next = LOAD_A;
                end
            end
            LOAD_A: begin
                o_row_rdy   = 1'b1;
                w_beat      = i_row_vld;
                w_last_beat = i_row_vld && (r_beat_cnt == BEAT_W'(SIZE - 1));
                if (w_last_beat) begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                w_cap_any = i_sa_c_vld;
                if (r_wait_cnt == '0) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                w_cap_any  = i_sa_c_vld;
                // The drain request runs for the first SIZE cycles of DRAIN;
                // the timeout counter doubles as the drain cycle index.
                o_sa_c_vld = (r_tmo_cnt < TMO_W'(SIZE));
                if (r_cap_cnt == CAP_W'(SIZE)) begin
                    w_next = OUT;
                end else if (r_tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                    w_tmo_hit = 1'b1;
                    w_next    = OUT;
                end
            end
            OUT: begin
                o_res_vld = !w_buf_empty;
                if (w_buf_empty || (i_res_rdy && (w_buf_count == CAP_W'(1)))) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign w_push     = w_cap_any && (r_cap_cnt != CAP_W'(SIZE)) && !w_buf_full;
    assign w_ovf      = w_cap_any && (r_cap_cnt == CAP_W'(SIZE));
    assign w_pop      = o_res_vld && i_res_rdy;
    assign o_res_last = o_res_vld && (w_buf_count == CAP_W'(1));
    assign o_sa_we    = r_we;
    assign o_sa_a_vld = r_a_vld;
    assign o_sa_rows  = r_rows;
    assign o_err      = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt <= '0;
            r_wait_cnt <= '0;
            r_tmo_cnt  <= '0;
            r_cap_cnt  <= '0;
            r_err      <= 1'b0;
            r_we       <= 1'b0;
            r_a_vld    <= 1'b0;
            r_rows     <= '0;
        end else begin
            r_we    <= w_beat && (r_state == LOAD_B);
            r_a_vld <= w_beat && (r_state == LOAD_A);
            if (w_beat) begin
                r_rows     <= i_row;
                r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
            end

            // WAIT lasts DRAIN_LAT+1 cycles: the cycle the last A row is
            // on o_sa_a_vld, then DRAIN_LAT idle cycles.
            if ((r_state == LOAD_A) && w_last_beat) begin
                r_wait_cnt <= WAIT_W'(DRAIN_LAT);
            end else if ((r_state == WAIT) && (r_wait_cnt != '0)) begin
                r_wait_cnt <= r_wait_cnt - 1'b1;
            end

            if (r_state == DRAIN) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end else begin
                r_tmo_cnt <= '0;
            end

            if (w_push) begin
                r_cap_cnt <= r_cap_cnt + 1'b1;
            end else if ((r_state == OUT) && (w_next == IDLE)) begin
                r_cap_cnt <= '0;
            end

            if ((r_state == IDLE) && i_start) begin
                r_err <= 1'b0;
            end else if (w_ovf || w_tmo_hit) begin
                r_err <= 1'b1;
            end
        end
    end

    sa_res_buf #(
        .WIDTH (WIDTH),
        .SIZE  (SIZE)
    ) u_res_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (i_sa_c_rows),
        .i_pop   (w_pop),
        .o_data  (o_res_row),
        .o_full  (w_buf_full),
        .o_empty (w_buf_empty),
        .o_count (w_buf_count)
    );

endmodule
